// File: rtl/axi_dw_w_splitter_if.sv
// rtl/axi_dw_w_splitter_if.sv - split command, wide W and narrow W signal bundle for axi_dw_w_splitter
interface axi_dw_w_splitter_if #(
    parameter int unsigned SlvPortDataWidth = 64,
    parameter int unsigned MstPortDataWidth = 32,
    parameter int unsigned UserWidth        = 8
);
    localparam int unsigned SlvBytes = SlvPortDataWidth / 8;
    localparam int unsigned MstBytes = MstPortDataWidth / 8;
    localparam int unsigned OffWidth = (SlvBytes > 1) ? $clog2(SlvBytes) : 1;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [OffWidth-1:0]         cmd_offset;
    logic [2:0]                  cmd_size;
    logic [7:0]                  cmd_len;

    logic [SlvPortDataWidth-1:0] slv_w_data;
    logic [SlvBytes-1:0]         slv_w_strb;
    logic [UserWidth-1:0]        slv_w_user;
    logic                        slv_w_last;
    logic                        slv_w_valid;
    logic                        slv_w_ready;

    logic [MstPortDataWidth-1:0] mst_w_data;
    logic [MstBytes-1:0]         mst_w_strb;
    logic [UserWidth-1:0]        mst_w_user;
    logic                        mst_w_last;
    logic                        mst_w_valid;
    logic                        mst_w_ready;

    logic                        protocol_err;

    // Splitter side: consumes commands and wide beats, produces narrow beats.
    modport slave (
        input  cmd_valid, cmd_offset, cmd_size, cmd_len,
        output cmd_ready,
        input  slv_w_data, slv_w_strb, slv_w_user, slv_w_last, slv_w_valid,
        output slv_w_ready,
        output mst_w_data, mst_w_strb, mst_w_user, mst_w_last, mst_w_valid,
        input  mst_w_ready,
        output protocol_err
    );

    modport master (
        output cmd_valid, cmd_offset, cmd_size, cmd_len,
        input  cmd_ready,
        output slv_w_data, slv_w_strb, slv_w_user, slv_w_last, slv_w_valid,
        input  slv_w_ready,
        input  mst_w_data, mst_w_strb, mst_w_user, mst_w_last, mst_w_valid,
        output mst_w_ready,
        input  protocol_err
    );
endinterface

// File: rtl/axi_dw_w_splitter.sv
// rtl/axi_dw_w_splitter.sv - downsizer W splitter; AXI_DW_W_SPLITTER_OUT_REG_EN adds a narrow-side spill register
module axi_dw_w_splitter #(
    parameter int unsigned SlvPortDataWidth = 64,
    parameter int unsigned MstPortDataWidth = 32,
    parameter int unsigned UserWidth        = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    axi_dw_w_splitter_if.slave bus
);
    localparam int unsigned SlvBytes     = SlvPortDataWidth / 8;
    localparam int unsigned MstBytes     = MstPortDataWidth / 8;
    localparam int unsigned Lanes        = SlvBytes / MstBytes;
    localparam int unsigned PtrWidth     = (SlvBytes > 1) ? $clog2(SlvBytes) : 1;
    localparam int unsigned LaneWidth    = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned MstOff       = $clog2(MstBytes);
    localparam int unsigned PayloadWidth = MstPortDataWidth + MstBytes + UserWidth + 1;

    typedef enum logic {IDLE, SPLIT} state_e;

    state_e                 state_q, state_d;
    logic [PtrWidth-1:0]    ptr_q, ptr_d;
    logic [2:0]             size_q, size_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [Lanes-1:0][MstPortDataWidth-1:0] data_lanes;
    logic [Lanes-1:0][MstBytes-1:0]         strb_lanes;
    logic [LaneWidth-1:0]   lane;
    logic [PtrWidth-1:0]    ptr_next;
    logic [PtrWidth-1:0]    offset_aligned;
    logic                   last_beat;
    logic                   consume;
    logic                   sel_valid;
    logic                   sel_ready;
    logic                   fire;
    logic [PayloadWidth-1:0] sel_payload;

    assign data_lanes = bus.slv_w_data;
    assign strb_lanes = bus.slv_w_strb;
    assign lane       = LaneWidth'(ptr_q >> MstOff);

    // Step of 2^size truncated to the pointer width wraps inside the wide word;
    // a full-width step collapses to zero and lands back on offset 0.
    assign ptr_next       = ptr_q + (PtrWidth'(1) << size_q);
    assign offset_aligned = bus.cmd_offset & ~((PtrWidth'(1) << bus.cmd_size) - PtrWidth'(1));
    assign last_beat      = (cnt_q == 8'd0);
    assign consume        = last_beat || (ptr_next == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        size_d           = size_q;
        cnt_d            = cnt_q;
        bus.cmd_ready    = 1'b0;
        bus.slv_w_ready  = 1'b0;
        bus.protocol_err = 1'b0;
        sel_valid        = 1'b0;
        sel_payload      = '0;
        fire             = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    ptr_d   = offset_aligned;
                    size_d  = bus.cmd_size;
                    cnt_d   = bus.cmd_len;
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                sel_valid       = bus.slv_w_valid;
                sel_payload     = {data_lanes[lane], strb_lanes[lane], bus.slv_w_user, last_beat};
                bus.slv_w_ready = sel_ready && consume;
                fire            = sel_valid && sel_ready;
                // WLAST is only checked; the narrow burst length always follows cnt.
                if (bus.slv_w_valid && sel_ready && consume) begin
                    bus.protocol_err = (bus.slv_w_last != last_beat);
                end
                if (fire) begin
                    ptr_d = ptr_next;
                    cnt_d = cnt_q - 8'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXI_DW_W_SPLITTER_OUT_REG_EN
    logic                    out_valid_q;
    logic                    skid_valid_q;
    logic [PayloadWidth-1:0] out_payload_q;
    logic [PayloadWidth-1:0] skid_payload_q;

    // The skid slot absorbs the beat selected in the cycle the output stalls,
    // so the upstream ready is registered yet throughput stays one beat per cycle.
    assign sel_ready = !skid_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
            out_payload_q  <= '0;
            skid_payload_q <= '0;
        end else if (!out_valid_q || bus.mst_w_ready) begin
            if (skid_valid_q) begin
                out_payload_q <= skid_payload_q;
                out_valid_q   <= 1'b1;
                skid_valid_q  <= 1'b0;
            end else begin
                out_payload_q <= sel_payload;
                out_valid_q   <= sel_valid;
            end
        end else if (fire) begin
            skid_payload_q <= sel_payload;
            skid_valid_q   <= 1'b1;
        end
    end

    assign {bus.mst_w_data, bus.mst_w_strb, bus.mst_w_user, bus.mst_w_last} = out_payload_q;
    assign bus.mst_w_valid = out_valid_q;
`else
    assign sel_ready = bus.mst_w_ready;
    assign {bus.mst_w_data, bus.mst_w_strb, bus.mst_w_user, bus.mst_w_last} = sel_payload;
    assign bus.mst_w_valid = sel_valid;
`endif
endmodule

// File: tb/tb_axi_dw_w_splitter.sv
// tb/tb_axi_dw_w_splitter.sv - scoreboard bench for axi_dw_w_splitter
module tb_axi_dw_w_splitter;
    localparam int SW = 64;
    localparam int MW = 32;
    localparam int UW = 8;
    localparam int SB = SW / 8;
    localparam int MB = MW / 8;
`ifdef AXI_DW_W_SPLITTER_OUT_REG_EN
    localparam bit OutReg = 1'b1;
`else
    localparam bit OutReg = 1'b0;
`endif

    typedef struct {
        logic [MW-1:0] data;
        logic [MB-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int            k;
    } nar_t;
    typedef struct {
        logic err;
        int   kend;
    } wide_exp_t;
    typedef struct {
        logic [SW-1:0] data;
        logic [SB-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } wbeat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_dw_w_splitter_if #(.SlvPortDataWidth(SW), .MstPortDataWidth(MW), .UserWidth(UW)) bus ();
    axi_dw_w_splitter #(.SlvPortDataWidth(SW), .MstPortDataWidth(MW), .UserWidth(UW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    nar_t      exp_q[$];
    wide_exp_t wexp_q[$];
    wbeat_t    wq[$];
    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 1;
    bit abort = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    initial begin
        bus.mst_w_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.mst_w_ready = 1'b1;
                1:       bus.mst_w_ready = ($urandom_range(0, 3) != 0);
                default: bus.mst_w_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a beat.
    initial begin
        logic          stall_p;
        logic [MW+MB+UW:0] stall_v;
        wide_exp_t     w;
        nar_t          n;
        stall_p = 1'b0;
        stall_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_p = 1'b0;
            end else begin
                if (stall_p) begin
                    chk("stall_valid", bus.mst_w_valid, 1'b1);
                    chk("stall_hold", {bus.mst_w_data, bus.mst_w_strb, bus.mst_w_user, bus.mst_w_last}, stall_v);
                end
                if (bus.slv_w_valid && bus.slv_w_ready) begin
                    if (wexp_q.size() == 0) begin
                        fail_now("unexpected_wide_handshake");
                    end else begin
                        w = wexp_q.pop_front();
                        chk("protocol_err", bus.protocol_err, w.err);
                        if (!OutReg) begin
                            chk("consume_with_narrow", bus.mst_w_valid && bus.mst_w_ready, 1'b1);
                            if (exp_q.size() > 0) chk("consume_index", exp_q[0].k, w.kend);
                        end
                    end
                end else begin
                    chk("protocol_err_quiet", bus.protocol_err, 1'b0);
                end
                if (!OutReg && !bus.mst_w_ready) chk("slv_ready_backpressure", bus.slv_w_ready, 1'b0);
                if (bus.mst_w_valid && bus.mst_w_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_narrow_beat");
                    end else begin
                        n = exp_q.pop_front();
                        chk("mst_data", bus.mst_w_data, n.data);
                        chk("mst_strb", bus.mst_w_strb, n.strb);
                        chk("mst_user", bus.mst_w_user, n.user);
                        chk("mst_last", bus.mst_w_last, n.last);
                    end
                end
                stall_p = bus.mst_w_valid && !bus.mst_w_ready;
                stall_v = {bus.mst_w_data, bus.mst_w_strb, bus.mst_w_user, bus.mst_w_last};
            end
        end
    end

    function automatic int nbeats(input int off, input int size, input int len);
        int step = 1 << size;
        int start = off & ~(step - 1);
        return (start + len * step) / SB + 1;
    endfunction

    // Reference: narrow beat k sits at byte address start + k*2^size of the burst;
    // its wide beat is that address / SlvBytes and its lane is (address mod SlvBytes) / MstBytes.
    task automatic build_expect(input int off, input int size, input int len);
        int step = 1 << size;
        int start = off & ~(step - 1);
        int nw = nbeats(off, size, len);
        int kend[];
        logic [SW-1:0] d;
        logic [SB-1:0] s;
        nar_t n;
        kend = new[nw];
        for (int k = 0; k <= len; k++) begin
            int a = start + k * step;
            int w = a / SB;
            int ln = (a % SB) / MB;
            d = wq[w].data;
            s = wq[w].strb;
            n.data = d[ln*MW +: MW];
            n.strb = s[ln*MB +: MB];
            n.user = wq[w].user;
            n.last = (k == len);
            n.k    = k;
            exp_q.push_back(n);
            kend[w] = k;
        end
        for (int j = 0; j < nw; j++) begin
            wide_exp_t we;
            we.err  = (wq[j].last != (j == nw - 1));
            we.kend = kend[j];
            wexp_q.push_back(we);
        end
    endtask

    task automatic fill_random(input int nw, input bit inject);
        wbeat_t b;
        int bad = $urandom_range(0, nw - 1);
        wq.delete();
        for (int j = 0; j < nw; j++) begin
            b.data = {$urandom, $urandom};
            b.strb = SB'($urandom);
            b.user = UW'($urandom);
            b.last = (j == nw - 1);
            if (inject && j == bad) b.last = ~b.last;
            wq.push_back(b);
        end
    endtask

    task automatic run_burst(input int off, input int size, input int len);
        bit ok;
        build_expect(off, size, len);
        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_offset = 3'(off);
        bus.cmd_size   = 3'(size);
        bus.cmd_len    = 8'(len);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (abort) return;
            ok = bus.cmd_ready;
        end
        if (!ok) begin
            fail_now("cmd_handshake_timeout");
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < wq.size(); j++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            bus.slv_w_valid = 1'b1;
            bus.slv_w_data  = wq[j].data;
            bus.slv_w_strb  = wq[j].strb;
            bus.slv_w_user  = wq[j].user;
            bus.slv_w_last  = wq[j].last;
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
                @(negedge clk);
                if (abort) return;
                ok = bus.slv_w_ready;
            end
            if (!ok) begin
                fail_now("wide_handshake_timeout");
                return;
            end
            @(posedge clk);
            #1;
            bus.slv_w_valid = 1'b0;
        end
    endtask

    task automatic wait_first_narrow();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mst_w_valid && bus.mst_w_ready) return;
        end
        fail_now("first_narrow_timeout");
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && wexp_q.size() == 0) return;
            @(negedge clk);
        end
        fail_now("drain_timeout");
        exp_q.delete();
        wexp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        chk({tag, "_mst_valid"}, bus.mst_w_valid, 1'b0);
        chk({tag, "_slv_ready"}, bus.slv_w_ready, 1'b0);
        chk({tag, "_mst_last"}, bus.mst_w_last, 1'b0);
        chk({tag, "_protocol_err"}, bus.protocol_err, 1'b0);
        chk({tag, "_mst_data"}, {bus.mst_w_data, bus.mst_w_strb, bus.mst_w_user}, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wbeat_t b;
        bus.cmd_valid   = 1'b0;
        bus.cmd_offset  = '0;
        bus.cmd_size    = '0;
        bus.cmd_len     = '0;
        bus.slv_w_valid = 1'b0;
        bus.slv_w_data  = '0;
        bus.slv_w_strb  = '0;
        bus.slv_w_user  = '0;
        bus.slv_w_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_mode = 0;
        wq.delete();
        b = '{64'h11112222_33334444, 8'hFF, 8'h5A, 1'b1};
        wq.push_back(b);
        run_burst(0, 2, 1);
        wait_drained();

        wq.delete();
        b = '{64'hAAAA0001_BBBB0002, 8'hFF, 8'h01, 1'b0};
        wq.push_back(b);
        b = '{64'hCCCC0003_DDDD0004, 8'h3C, 8'h02, 1'b1};
        wq.push_back(b);
        run_burst(4, 2, 2);
        wait_drained();

        fill_random(nbeats(6, 0, 3), 1'b0);
        run_burst(6, 0, 3);
        wait_drained();

        fill_random(nbeats(0, 2, 3), 1'b0);
        fork
            run_burst(0, 2, 3);
            begin
                wait_first_narrow();
                rdy_mode = 2;
                repeat (6) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_drained();

        fill_random(nbeats(0, 2, 3), 1'b0);
        wq[0].last = 1'b1;
        run_burst(0, 2, 3);
        wait_drained();

        fill_random(nbeats(0, 2, 3), 1'b0);
        fork
            run_burst(0, 2, 3);
            begin
                wait_first_narrow();
                @(posedge clk);
                #1;
                abort = 1'b1;
                rst_n = 1'b0;
                bus.cmd_valid   = 1'b0;
                bus.slv_w_valid = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        exp_q.delete();
        wexp_q.delete();
        @(negedge clk);
        check_idle("post_reset");
        abort = 1'b0;
        fill_random(nbeats(4, 2, 1), 1'b0);
        run_burst(4, 2, 1);
        wait_drained();

        fill_random(nbeats(3, 0, 255), 1'b0);
        run_burst(3, 0, 255);
        wait_drained();

        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            int off = $urandom_range(0, SB - 1);
            int size = $urandom_range(0, 2);
            int len = $urandom_range(0, 9);
            fill_random(nbeats(off, size, len), ($urandom_range(0, 5) == 0));
            run_burst(off, size, len);
        end
        wait_drained();
        chk("narrow_queue_drained", exp_q.size(), 0);
        chk("wide_queue_drained", wexp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
